// File: rtl/smart_ctrl.sv
// SMART access-protection sequencer: peripheral-mapped region bounds, trusted-region
// entry/exit FSM and violation-to-reset stretcher.
module smart_ctrl #(
    parameter logic [14:0] BASE_ADDR      = 15'h0190,
    parameter int unsigned RST_CYCLES     = 4,
    parameter logic [15:0] LOW_CODE_INIT  = 16'h0000,
    parameter logic [15:0] HIGH_CODE_INIT = 16'h0000,
    parameter logic [15:0] LOW_SAFE_INIT  = 16'h0000,
    parameter logic [15:0] HIGH_SAFE_INIT = 16'h0000
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic [15:0] mem_addr,
    input  logic        mem_en,
    input  logic [15:0] ins_addr,
    input  logic        disable_debug,
    output logic        in_safe_area,
    output logic        mem_block,
    output logic        viol_reset
);

    typedef enum logic [1:0] {OUTSIDE, INSIDE, HOLD} state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(RST_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        viol_reset_q;

    logic        enable, lock, viol_flag;
    logic [15:0] low_code, high_code, low_safe, high_safe;

    logic        sel, wr;
    logic [2:0]  idx;
    logic        ctrl_wr, bound_wr_ok;
    logic        code_hit, safe_hit, viol, enter_hold;
    logic [15:0] rdata;

    function automatic logic [15:0] byte_merge(input logic [15:0] cur,
                                               input logic [15:0] din,
                                               input logic [1:0]  we);
        logic [15:0] res;
        res = cur;
        if (we[0]) res[7:0]  = din[7:0];
        if (we[1]) res[15:8] = din[15:8];
        return res;
    endfunction

    assign sel         = per_en && (per_addr[13:3] == BASE_ADDR[14:4]);
    assign idx         = per_addr[2:0];
    assign wr          = sel && (per_we != 2'b00);
    assign ctrl_wr     = wr && (idx == 3'd0) && per_we[0];
    // Bounds are frozen by LOCK and also while trusted code is executing.
    assign bound_wr_ok = wr && !lock && (state != INSIDE);

    assign code_hit   = (ins_addr >= low_code) && (ins_addr <= high_code);
    assign safe_hit   = mem_en && (mem_addr >= low_safe) && (mem_addr <= high_safe);
    assign viol       = enable && !disable_debug && (state == OUTSIDE) &&
                        (safe_hit || (code_hit && (ins_addr != low_code)));
    assign enter_hold = viol;
    assign mem_block  = viol && safe_hit;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            enable    <= 1'b0;
            lock      <= 1'b0;
            viol_flag <= 1'b0;
        end else begin
            if (ctrl_wr && !lock) enable <= per_din[0];
            if (ctrl_wr && per_din[1]) lock <= 1'b1;
            // Hardware set has priority over a same-cycle W1C.
            if (enter_hold)                  viol_flag <= 1'b1;
            else if (ctrl_wr && per_din[2])  viol_flag <= 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            low_code  <= LOW_CODE_INIT;
            high_code <= HIGH_CODE_INIT;
            low_safe  <= LOW_SAFE_INIT;
            high_safe <= HIGH_SAFE_INIT;
        end else if (bound_wr_ok) begin
            case (idx)
                3'd1:    low_code  <= byte_merge(low_code,  per_din, per_we);
                3'd2:    high_code <= byte_merge(high_code, per_din, per_we);
                3'd3:    low_safe  <= byte_merge(low_safe,  per_din, per_we);
                3'd4:    high_safe <= byte_merge(high_safe, per_din, per_we);
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 16'h0000;
        case (idx)
            3'd0:    rdata = {12'h000, (state == INSIDE), viol_flag, lock, enable};
            3'd1:    rdata = low_code;
            3'd2:    rdata = high_code;
            3'd3:    rdata = low_safe;
            3'd4:    rdata = high_safe;
            default: rdata = 16'h0000;
        endcase
    end

    assign per_dout = (sel && (per_we == 2'b00)) ? rdata : 16'h0000;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state        <= OUTSIDE;
            cnt          <= 8'd0;
            viol_reset_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            viol_reset_q <= (state_nxt == HOLD);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OUTSIDE: begin
                if (viol) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else if (enable && (ins_addr == low_code)) begin
                    state_nxt = INSIDE;
                end
            end
            INSIDE: begin
                if (!code_hit || !enable) state_nxt = OUTSIDE;
            end
            HOLD: begin
                if (cnt == 8'd0) state_nxt = OUTSIDE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: state_nxt = OUTSIDE;
        endcase
    end

    assign in_safe_area = (state == INSIDE);
    assign viol_reset   = viol_reset_q;

endmodule

// File: tb/tb_smart_ctrl.sv
// Scoreboard bench for smart_ctrl: directed stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_smart_ctrl;

    localparam logic [10:0] BASE_W = 11'h019;
    localparam int ID_DOUT = 0, ID_SAFE = 1, ID_BLOCK = 2, ID_VRST = 3;

    logic        mclk;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] ins_addr;
    logic        disable_debug;
    logic        in_safe_area;
    logic        mem_block;
    logic        viol_reset;

    smart_ctrl dut (
        .mclk          (mclk),
        .puc_rst       (puc_rst),
        .per_addr      (per_addr),
        .per_din       (per_din),
        .per_en        (per_en),
        .per_we        (per_we),
        .per_dout      (per_dout),
        .mem_addr      (mem_addr),
        .mem_en        (mem_en),
        .ins_addr      (ins_addr),
        .disable_debug (disable_debug),
        .in_safe_area  (in_safe_area),
        .mem_block     (mem_block),
        .viol_reset    (viol_reset)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    function automatic logic [15:0] observe(input int id);
        case (id)
            ID_DOUT:  return per_dout;
            ID_SAFE:  return {15'h0, in_safe_area};
            ID_BLOCK: return {15'h0, mem_block};
            default:  return {15'h0, viol_reset};
        endcase
    endfunction

    always @(negedge mclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [15:0] act;
                act = observe(sb[i].id);
                checks++;
                if (sb[i].cyc < cyc) begin
                    failures++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
                end else if (act !== sb[i].exp) begin
                    failures++;
                    $display("FAIL %s: cycle %0d actual=0x%04h required=0x%04h",
                             sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input string name, input int id, input int off, input logic [15:0] exp);
        chk_t c;
        c.cyc  = cyc + off;
        c.id   = id;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic wr_be(input logic [2:0] idx, input logic [15:0] data, input logic [1:0] be);
        per_en   = 1'b1;
        per_we   = be;
        per_addr = {BASE_W, idx};
        per_din  = data;
        step();
        per_en   = 1'b0;
        per_we   = 2'b00;
        per_din  = 16'h0000;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] data);
        wr_be(idx, data, 2'b11);
    endtask

    task automatic rd(input string name, input logic [2:0] idx, input logic [15:0] exp);
        per_en   = 1'b1;
        per_we   = 2'b00;
        per_addr = {BASE_W, idx};
        expect_at(name, ID_DOUT, 0, exp);
        step();
        per_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        puc_rst = 1'b1; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
        mem_addr = 16'h0000; mem_en = 1'b0; ins_addr = 16'h4000; disable_debug = 1'b0;
        repeat (2) step();
        puc_rst = 1'b0;

        // reset state
        expect_at("rst_in_safe", ID_SAFE, 0, 16'h0);
        expect_at("rst_viol_reset", ID_VRST, 0, 16'h0);
        rd("rst_ctrl", 3'd0, 16'h0000);
        rd("rst_low_safe", 3'd3, 16'h0000);
        per_en = 1'b1; per_we = 2'b00; per_addr = 14'h0000;
        expect_at("unsel_dout", ID_DOUT, 0, 16'h0000);
        step();
        per_en = 1'b0;

        // config and lock
        wr(3'd3, 16'h0200);
        rd("low_safe_wr", 3'd3, 16'h0200);
        wr_be(3'd4, 16'hABCD, 2'b10);
        rd("high_safe_hi_byte", 3'd4, 16'hAB00);
        wr(3'd5, 16'hFFFF);
        rd("idx5_reads0", 3'd5, 16'h0000);
        wr(3'd0, 16'h0001);
        wr(3'd0, 16'h0003);
        wr(3'd3, 16'h0300);
        rd("locked_low_safe", 3'd3, 16'h0200);
        wr(3'd0, 16'h0000);
        rd("locked_enable", 3'd0, 16'h0003);

        puc_rst = 1'b1;
        step();
        puc_rst = 1'b0;
        rd("post_rst_ctrl", 3'd0, 16'h0000);

        wr(3'd1, 16'hE000);
        wr(3'd2, 16'hE0FF);
        wr(3'd3, 16'h0200);
        wr(3'd4, 16'h020F);
        wr(3'd0, 16'h0001);

        // legal entry, access inside, exit
        ins_addr = 16'hE000;
        expect_at("entry_before", ID_SAFE, 0, 16'h0);
        expect_at("entry_after", ID_SAFE, 1, 16'h1);
        step();
        ins_addr = 16'hE002; mem_en = 1'b1; mem_addr = 16'h0205;
        expect_at("inside_access_block", ID_BLOCK, 0, 16'h0);
        expect_at("inside_access_vrst", ID_VRST, 1, 16'h0);
        expect_at("inside_still", ID_SAFE, 1, 16'h1);
        step();
        mem_en = 1'b0;
        wr(3'd1, 16'h1234);
        rd("inside_bound_frozen", 3'd1, 16'hE000);
        rd("inside_ctrl", 3'd0, 16'h0009);
        ins_addr = 16'hE100;
        expect_at("exit_before", ID_SAFE, 0, 16'h1);
        expect_at("exit_after", ID_SAFE, 1, 16'h0);
        step();
        ins_addr = 16'h4000;

        // key access from outside, disable_debug during HOLD does not abort
        mem_en = 1'b1; mem_addr = 16'h020F;
        expect_at("key_block", ID_BLOCK, 0, 16'h1);
        expect_at("key_vrst_c0", ID_VRST, 0, 16'h0);
        for (int k = 1; k <= 4; k++) expect_at("key_vrst_hold", ID_VRST, k, 16'h1);
        expect_at("key_vrst_end", ID_VRST, 5, 16'h0);
        expect_at("key_no_entry", ID_SAFE, 1, 16'h0);
        step();
        mem_en = 1'b0; disable_debug = 1'b1;
        repeat (2) step();
        disable_debug = 1'b0;
        repeat (3) step();
        rd("key_viol_flag", 3'd0, 16'h0005);
        wr(3'd0, 16'h0005);
        rd("viol_w1c", 3'd0, 16'h0001);

        // mid-region entry
        ins_addr = 16'hE010;
        expect_at("mid_block", ID_BLOCK, 0, 16'h0);
        expect_at("mid_in_safe", ID_SAFE, 1, 16'h0);
        expect_at("mid_vrst", ID_VRST, 1, 16'h1);
        step();
        ins_addr = 16'h4000;
        repeat (5) step();
        rd("mid_viol_flag", 3'd0, 16'h0005);
        wr(3'd0, 16'h0005);

        // violation beats same-cycle entry
        ins_addr = 16'hE000; mem_en = 1'b1; mem_addr = 16'h0200;
        expect_at("prec_block", ID_BLOCK, 0, 16'h1);
        expect_at("prec_in_safe", ID_SAFE, 1, 16'h0);
        expect_at("prec_vrst", ID_VRST, 1, 16'h1);
        expect_at("prec_vrst_last", ID_VRST, 4, 16'h1);
        expect_at("prec_vrst_end", ID_VRST, 5, 16'h0);
        step();
        ins_addr = 16'h4000; mem_en = 1'b0;
        repeat (5) step();
        wr(3'd0, 16'h0005);
        rd("prec_w1c", 3'd0, 16'h0001);

        // boundaries and debug suppression
        mem_en = 1'b1; mem_addr = 16'h01FF;
        expect_at("bnd_01ff_block", ID_BLOCK, 0, 16'h0);
        expect_at("bnd_01ff_vrst", ID_VRST, 1, 16'h0);
        step();
        mem_addr = 16'h0210;
        expect_at("bnd_0210_block", ID_BLOCK, 0, 16'h0);
        expect_at("bnd_0210_vrst", ID_VRST, 1, 16'h0);
        step();
        mem_addr = 16'h0200; disable_debug = 1'b1;
        expect_at("dbg_block", ID_BLOCK, 0, 16'h0);
        expect_at("dbg_vrst", ID_VRST, 1, 16'h0);
        step();
        mem_en = 1'b0; disable_debug = 1'b0;

        // ENABLE cleared while INSIDE forces exit and disables checks
        ins_addr = 16'hE000;
        expect_at("en_entry", ID_SAFE, 1, 16'h1);
        step();
        ins_addr = 16'hE002;
        expect_at("en_clr_still_in", ID_SAFE, 1, 16'h1);
        expect_at("en_clr_out", ID_SAFE, 2, 16'h0);
        wr(3'd0, 16'h0000);
        step();
        mem_en = 1'b1; mem_addr = 16'h0205;
        expect_at("dis_block", ID_BLOCK, 0, 16'h0);
        expect_at("dis_vrst", ID_VRST, 1, 16'h0);
        step();
        mem_en = 1'b0; ins_addr = 16'h4000;
        wr(3'd0, 16'h0001);

        // reset in the second HOLD cycle
        mem_en = 1'b1; mem_addr = 16'h0200;
        expect_at("rh_vrst1", ID_VRST, 1, 16'h1);
        expect_at("rh_vrst2", ID_VRST, 2, 16'h1);
        step();
        mem_en = 1'b0;
        step();
        puc_rst = 1'b1;
        expect_at("rh_vrst_drop", ID_VRST, 1, 16'h0);
        expect_at("rh_in_safe", ID_SAFE, 1, 16'h0);
        step();
        puc_rst = 1'b0;
        rd("rh_ctrl", 3'd0, 16'h0000);
        rd("rh_low_code", 3'd1, 16'h0000);

        begin
            int n = 0;
            while (sb.size() > 0 && n < 20) begin
                step();
                n++;
            end
            if (sb.size() > 0) begin
                $display("FAIL drain: %0d checks never evaluated", sb.size());
                checks   += sb.size();
                failures += sb.size();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smart_ctrl.md
Name: smart_ctrl

Overview:
- Sequencer and configuration block for the SMART memory-access protection path.
- Holds the protected-region bounds in peripheral-mapped registers (openMSP430 peripheral bus) and runs the entry/exit state machine for the trusted code region.
- Detects key-region access violations and stretches them into a fixed-length reset request for the reset generator.
- Replaces hard-wired region parameters with runtime-configurable bounds that software can lock.

Parameters:
- BASE_ADDR, 15'h0190: byte base address of the register bank (16-byte aligned).
- RST_CYCLES, 4: length of the viol_reset pulse in mclk cycles (1..255).
- LOW_CODE_INIT, 16'h0000: reset value of LOW_CODE.
- HIGH_CODE_INIT, 16'h0000: reset value of HIGH_CODE.
- LOW_SAFE_INIT, 16'h0000: reset value of LOW_SAFE.
- HIGH_SAFE_INIT, 16'h0000: reset value of HIGH_SAFE.

Ports:
- mclk  in  1  system clock; all state changes on its rising edge.
- puc_rst  in  1  synchronous, active-high reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral access strobe.
- per_we  in  2  byte write enables; 00 = read.
- per_dout  out  16  read data; 0 when not selected.
- mem_addr  in  16  data-memory byte address.
- mem_en  in  1  data-memory access this cycle.
- ins_addr  in  16  current instruction address.
- disable_debug  in  1  high suppresses new violations.
- in_safe_area  out  1  high while the FSM is in INSIDE.
- mem_block  out  1  combinational; high when the current access is a violation (data gating).
- viol_reset  out  1  registered reset request.

Behaviour:
- Select: per_en & (per_addr[13:3] == BASE_ADDR[14:4]). Register index = per_addr[2:0].
- Register map by index:
  - 0 CTRL: bit0 ENABLE, bit1 LOCK, bit2 VIOL, bit3 INSIDE (RO); all other bits read 0.
  - 1 LOW_CODE; 2 HIGH_CODE; 3 LOW_SAFE; 4 HIGH_SAFE.
  - 5..7: read 0, writes ignored.
- Reads are combinational: per_dout = selected & (per_we == 0) ? reg : 0.
- Writes take effect at the next edge. per_we[0] writes bits 7:0; per_we[1] writes bits 15:8.
- LOCK: writing 1 sets it; cleared only by puc_rst.
- While LOCK = 1: writes to indices 1..4 and to ENABLE are ignored.
- While the state is INSIDE: writes to indices 1..4 are ignored.
- VIOL: set by hardware; W1C (a write of 1 to bit2 clears it). Hardware set wins over a same-cycle clear.
- Reset values: ENABLE = 0, LOCK = 0, VIOL = 0, bounds = *_INIT, state OUTSIDE, viol_reset = 0, counter = 0.
- All range checks are unsigned and inclusive: code_hit = LOW_CODE <= ins_addr <= HIGH_CODE; safe_hit = mem_en & LOW_SAFE <= mem_addr <= HIGH_SAFE.
- viol (combinational) = ENABLE & ~disable_debug & state != HOLD & ( (state == OUTSIDE & safe_hit) | (state == OUTSIDE & code_hit & ins_addr != LOW_CODE) ).
- mem_block = viol & safe_hit.
- FSM states OUTSIDE, INSIDE, HOLD:
  - OUTSIDE: viol -> HOLD. Else ENABLE & ins_addr == LOW_CODE -> INSIDE.
  - INSIDE: ~code_hit -> OUTSIDE. ENABLE = 0 -> OUTSIDE. Safe accesses are allowed here.
  - HOLD: counter decrements each cycle; at 0 -> OUTSIDE.
- Entering HOLD: counter loads RST_CYCLES-1 and VIOL is set.
- viol_reset = (state == HOLD). It rises the cycle after the violating cycle and stays high exactly RST_CYCLES cycles.
- Precedence: a violation and an entry in the same cycle -> violation wins.
- disable_debug does not abort an active HOLD.
- puc_rst in any state returns to OUTSIDE at the next edge and drops viol_reset; the register bank reinitialises.
- ENABLE = 0: FSM forced to OUTSIDE (from INSIDE), no violations, mem_block = 0.

Test Plan:
- Config/lock: write LOW_SAFE = 0x0200, read back 0x0200. Set LOCK, write 0x0300, read 0x0200. Clear ENABLE while locked -> ENABLE stays 1.
- Legal entry: bounds code 0xE000..0xE0FF, safe 0x0200..0x020F, ENABLE = 1. ins_addr = 0xE000 -> in_safe_area = 1 next cycle. Reads of 0x0205 -> no viol_reset. ins_addr = 0xE100 -> in_safe_area = 0 next cycle.
- Key access from outside: state OUTSIDE, mem_en = 1, mem_addr = 0x020F -> mem_block = 1 same cycle. viol_reset high for exactly 4 cycles starting next cycle; VIOL = 1.
- Mid-region entry: ins_addr jumps to 0xE010 from OUTSIDE -> HOLD; in_safe_area stays 0.
- Boundaries and debug: mem_addr = 0x01FF and 0x0210 -> no violation. disable_debug = 1 with mem_addr = 0x0200 -> no violation.
- Reset mid-HOLD: assert puc_rst during the 2nd HOLD cycle -> viol_reset = 0 and state OUTSIDE next edge. VIOL W1C clears without a new violation.
